// File: rtl/sha512_pkg.sv
// Shared SHA-512 constants, HMAC pad/length constants and engine state type.
// SHA512_2ROUND_EN selects the two-rounds-per-clock compression core.
package sha512_pkg;

  localparam logic [63:0] K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [7:0]   IPAD    = 8'h36;
  localparam logic [7:0]   OPAD    = 8'h5c;
  localparam logic [127:0] LEN_M36 = 128'd1312;
  localparam logic [127:0] LEN_M64 = 128'd1536;

  typedef enum logic [2:0] {IDLE, IN1, IN2, OUT1, OUT2, FIN} state_t;

`ifdef SHA512_2ROUND_EN
  localparam int ROUNDS_PER_CLK = 2;
`else
  localparam int ROUNDS_PER_CLK = 1;
`endif
  localparam int BLOCK_CYCLES = 2 + 80 / ROUNDS_PER_CLK;

endpackage

// File: rtl/sha512_block.sv
// One SHA-512 block compression: load, 80 rounds, feed-forward.
// SHA512_2ROUND_EN chains two rounds per clock.
module sha512_block
  import sha512_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [511:0]  cv_in,
  input  logic [1023:0] block,
  output logic [511:0]  cv_out,
  output logic          blk_done
);

  localparam logic [6:0] LAST = 7'((BLOCK_CYCLES - 2) * ROUNDS_PER_CLK);

  logic              busy;
  logic [6:0]        rnd;
  logic [7:0][63:0]  work, chain, work_nxt;
  logic [15:0][63:0] win, win_nxt;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // win[15] is the word consumed this round; the newest word enters at win[0].
  function automatic logic [1023:0] sched_f(input logic [15:0][63:0] w);
    logic [63:0] s0, s1;
    s0 = rotr(w[14], 1) ^ rotr(w[14], 8) ^ (w[14] >> 7);
    s1 = rotr(w[1], 19) ^ rotr(w[1], 61) ^ (w[1] >> 6);
    return {w[14:0], s1 + w[6] + s0 + w[15]};
  endfunction

  // s[7] is a, s[0] is h.
  function automatic logic [511:0] round_f(input logic [7:0][63:0] s, input logic [63:0] k,
                                           input logic [63:0] w);
    logic [63:0] t1, t2;
    t1 = s[0] + (rotr(s[3], 14) ^ rotr(s[3], 18) ^ rotr(s[3], 41))
         + ((s[3] & s[2]) ^ (~s[3] & s[1])) + k + w;
    t2 = (rotr(s[7], 28) ^ rotr(s[7], 34) ^ rotr(s[7], 39))
         + ((s[7] & s[6]) ^ (s[7] & s[5]) ^ (s[6] & s[5]));
    return {t1 + t2, s[7], s[6], s[5], s[4] + t1, s[3], s[2], s[1]};
  endfunction

  always_comb begin
    work_nxt = round_f(work, K[rnd], win[15]);
    win_nxt  = sched_f(win);
`ifdef SHA512_2ROUND_EN
    work_nxt = round_f(work_nxt, K[rnd + 7'd1], win_nxt[15]);
    win_nxt  = sched_f(win_nxt);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      rnd  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rnd  <= '0;
    end else if (busy) begin
      if (rnd == LAST) busy <= 1'b0;
      else             rnd  <= rnd + 7'(ROUNDS_PER_CLK);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      work  <= cv_in;
      chain <= cv_in;
      win   <= block;
    end else if (busy && rnd != LAST) begin
      work <= work_nxt;
      win  <= win_nxt;
    end
  end

  // Feed-forward is combinational during the final cycle so the caller can capture it on blk_done.
  assign blk_done = busy && (rnd == LAST);
  for (genvar i = 0; i < 8; i++) begin : g_ff
    assign cv_out[64*i +: 64] = chain[i] + work[i];
  end

endmodule

// File: rtl/hmac_sha512_engine.sv
// HMAC-SHA512 over a 36- or 64-byte message; four compressions through one core.
// Block timing follows SHA512_2ROUND_EN in the package.
module hmac_sha512_engine
  import sha512_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  output logic          done,
  input  logic          mode,
  input  logic [1023:0] key,
  input  logic [511:0]  msg,
  output logic [511:0]  out
);

  state_t        state;
  logic          start, mode_q, blk_done;
  logic [511:0]  msg_q, cv, dig, core_cv_in, core_cv_out;
  logic [1023:0] core_blk;

  always_comb begin
    core_cv_in = IV;
    core_blk   = '0;
    case (state)
      IN1:  core_blk = key ^ {128{IPAD}};
      IN2: begin
        core_cv_in = cv;
        core_blk   = mode_q ? {msg_q, 8'h80, 376'h0, LEN_M64}
                            : {msg_q[511:224], 8'h80, 600'h0, LEN_M36};
      end
      OUT1: core_blk = key ^ {128{OPAD}};
      OUT2: begin
        core_cv_in = cv;
        core_blk   = {dig, 8'h80, 376'h0, LEN_M64};
      end
      default: ;
    endcase
  end

  sha512_block u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cv_in    (core_cv_in),
    .block    (core_blk),
    .cv_out   (core_cv_out),
    .blk_done (blk_done)
  );

  // Next start is issued on the edge that captures the previous result, keeping windows back-to-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      out    <= '0;
      start  <= 1'b0;
      mode_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          msg_q  <= msg;
          mode_q <= mode;
          start  <= 1'b1;
          state  <= IN1;
        end
        IN1:  if (blk_done) begin state <= IN2;  start <= 1'b1; end
        IN2:  if (blk_done) begin state <= OUT1; start <= 1'b1; end
        OUT1: if (blk_done) begin state <= OUT2; start <= 1'b1; end
        OUT2: if (blk_done) begin
          state <= FIN;
          out   <= core_cv_out;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Hi/Ho and the inner digest are always rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (blk_done) begin
      case (state)
        IN1, OUT1: cv  <= core_cv_out;
        IN2:       dig <= core_cv_out;
        default: ;
      endcase
    end
  end

endmodule
